// File: rtl/i2c_slave_responder.sv
// I2C target with a small register bank: 7-bit address match, register
// pointer load, auto-incrementing writes and reads, open-drain SDA drive.
module i2c_slave_responder #(
    parameter logic [6:0]  SLAVE_ADDRESS          = 7'h68,
    parameter int unsigned DATA_WIDTH             = 8,
    parameter int unsigned REGISTER_ADDRESS_WIDTH = 8,
    parameter int unsigned MEM_DEPTH              = 16
) (
    input  logic                              pclk,
    input  logic                              areset_n,
    input  logic                              scl_i,
    input  logic                              sda_i,
    output logic                              sda_oe,
    output logic                              busy,
    output logic                              wr_valid,
    output logic [REGISTER_ADDRESS_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]             wr_data
);
    localparam int unsigned PTR_W = $clog2(MEM_DEPTH);

    typedef enum logic [3:0] {
        IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK,
        WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    state_t                 state, state_next;
    logic                   scl_s1, scl_s2, scl_d;
    logic                   sda_s1, sda_s2, sda_d;
    logic                   scl_rise, scl_fall, start_det, stop_det;
    logic [3:0]             cnt;
    logic [DATA_WIDTH-1:0]  shreg;
    logic [PTR_W-1:0]       ptr;
    logic [DATA_WIDTH-1:0]  bank [MEM_DEPTH];
    logic [DATA_WIDTH-1:0]  rd_byte, wr_byte;
    logic                   shift_en, cnt_clr, cnt_inc;
    logic                   ptr_load, ptr_inc, bank_we;
    logic                   oe_next, busy_next;

    // Synchronize the bus pins and keep one delayed copy for edge detection;
    // reset to the idle (released) bus level so no false edges appear.
    always_ff @(posedge pclk or negedge areset_n) begin
        if (!areset_n) begin
            {scl_s1, scl_s2, scl_d} <= '1;
            {sda_s1, sda_s2, sda_d} <= '1;
        end else begin
            scl_s1 <= scl_i;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= sda_i;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    // Bus events derived from the synchronized pin levels.
    always_comb begin
        scl_rise  = scl_s2 & ~scl_d;
        scl_fall  = ~scl_s2 & scl_d;
        start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
        stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
        rd_byte   = bank[ptr];
        wr_byte   = {shreg[DATA_WIDTH-2:0], sda_s2};
    end

    // State register.
    always_ff @(posedge pclk or negedge areset_n) begin
        if (!areset_n) state <= IDLE;
        else           state <= state_next;
    end

    // Next-state and datapath control; START/STOP override any state.
    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        ptr_load   = 1'b0;
        ptr_inc    = 1'b0;
        bank_we    = 1'b0;
        oe_next    = sda_oe;
        busy_next  = busy;
        if (start_det) begin
            state_next = DEV_ADDR;
            cnt_clr    = 1'b1;
            oe_next    = 1'b0;
        end else if (stop_det) begin
            state_next = IDLE;
            oe_next    = 1'b0;
            busy_next  = 1'b0;
        end else begin
            case (state)
                DEV_ADDR, REG_ADDR, WR_DATA: begin
                    if (scl_rise && cnt != 4'd8) begin
                        shift_en = 1'b1;
                        cnt_inc  = 1'b1;
                        if (state == WR_DATA && cnt == 4'd7) begin
                            bank_we = 1'b1;
                            ptr_inc = 1'b1;
                        end
                    end else if (scl_fall && cnt == 4'd8) begin
                        if (state == DEV_ADDR) begin
                            if (shreg[DATA_WIDTH-1:1] == SLAVE_ADDRESS) begin
                                state_next = DEV_ACK;
                                oe_next    = 1'b1;
                                busy_next  = 1'b1;
                            end else begin
                                state_next = IGNORE;
                                busy_next  = 1'b0;
                            end
                        end else if (state == REG_ADDR) begin
                            state_next = REG_ACK;
                            oe_next    = 1'b1;
                            ptr_load   = 1'b1;
                        end else begin
                            state_next = WR_ACK;
                            oe_next    = 1'b1;
                        end
                    end
                end
                DEV_ACK, REG_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        cnt_clr = 1'b1;
                        oe_next = 1'b0;
                        if (state == DEV_ACK && shreg[0]) begin
                            // Read: the first data bit goes out on the same fall that ends ACK.
                            state_next = RD_DATA;
                            oe_next    = ~rd_byte[DATA_WIDTH-1];
                        end else if (state == DEV_ACK) begin
                            state_next = REG_ADDR;
                        end else begin
                            state_next = WR_DATA;
                        end
                    end
                end
                RD_DATA: begin
                    if (scl_rise) begin
                        cnt_inc = 1'b1;
                    end else if (scl_fall) begin
                        if (cnt == 4'd8) begin
                            state_next = RD_ACK;
                            oe_next    = 1'b0;
                            ptr_inc    = 1'b1;
                        end else begin
                            oe_next = ~rd_byte[3'd7 - cnt[2:0]];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise && sda_s2) begin
                        state_next = IGNORE;
                        busy_next  = 1'b0;
                    end else if (scl_fall) begin
                        state_next = RD_DATA;
                        cnt_clr    = 1'b1;
                        oe_next    = ~rd_byte[DATA_WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers: shifter, bit counter, pointer, bank and outputs.
    always_ff @(posedge pclk or negedge areset_n) begin
        if (!areset_n) begin
            cnt      <= '0;
            shreg    <= '0;
            ptr      <= '0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            for (int unsigned i = 0; i < MEM_DEPTH; i++) bank[i] <= '0;
        end else begin
            sda_oe   <= oe_next;
            busy     <= busy_next;
            wr_valid <= bank_we;
            if (shift_en) shreg <= wr_byte;
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 4'd1;
            if (ptr_load)     ptr <= shreg[PTR_W-1:0];
            else if (ptr_inc) ptr <= ptr + PTR_W'(1);
            if (bank_we) begin
                bank[ptr] <= wr_byte;
                wr_addr   <= REGISTER_ADDRESS_WIDTH'(ptr);
                wr_data   <= wr_byte;
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: bus-level master tasks with scoreboarded
// bus responses (ACKs, read bytes) and bank-write pulses.
module tb_i2c_slave_responder;
    localparam int Q = 50;

    logic       pclk = 1'b0;
    logic       areset_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       sda_oe, busy, wr_valid;
    logic [7:0] wr_addr, wr_data;

    typedef struct packed {
        logic       kind;
        logic [7:0] val;
    } rsp_t;

    rsp_t        bus_q[$];
    logic [15:0] wr_q[$];
    rsp_t        rsp_obs;
    event        rsp_ev;
    int          errors = 0;
    int          checks = 0;
    int          oe_cnt = 0;
    int          oe_snap;

    assign sda_bus = sda_m & ~sda_oe;

    always #5 pclk = ~pclk;

    i2c_slave_responder #(
        .SLAVE_ADDRESS(7'h68),
        .DATA_WIDTH(8),
        .REGISTER_ADDRESS_WIDTH(8),
        .MEM_DEPTH(16)
    ) dut (
        .pclk(pclk),
        .areset_n(areset_n),
        .scl_i(scl_m),
        .sda_i(sda_bus),
        .sda_oe(sda_oe),
        .busy(busy),
        .wr_valid(wr_valid),
        .wr_addr(wr_addr),
        .wr_data(wr_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #Q;
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; #Q;
        scl_m = 1'b1; #(2*Q);
        scl_m = 1'b0; #Q;
    endtask

    task automatic read_bit(output logic r);
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        r = sda_bus; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack);
        logic r;
        bus_q.push_back({1'b0, 7'b0, exp_ack});
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(r);
        rsp_obs = {1'b0, 7'b0, ~r};
        ->rsp_ev;
    endtask

    task automatic recv_byte(input logic [7:0] exp, input logic ack);
        logic       r;
        logic [7:0] d = '0;
        bus_q.push_back({1'b1, exp});
        for (int i = 0; i < 8; i++) begin
            read_bit(r);
            d = {d[6:0], r};
        end
        rsp_obs = {1'b1, d};
        ->rsp_ev;
        write_bit(~ack);
    endtask

    task automatic exp_wr(input logic [7:0] a, input logic [7:0] d);
        wr_q.push_back({a, d});
    endtask

    // Bus response monitor: ACK slots and read bytes against the queue.
    initial forever begin
        rsp_t e;
        @(rsp_ev);
        checks++;
        if (bus_q.size() == 0) begin
            errors++;
            $display("FAIL bus_unexpected: got %0h expected none", rsp_obs.val);
        end else begin
            e = bus_q.pop_front();
            if (e != rsp_obs) begin
                errors++;
                $display("FAIL %s: got %0h expected %0h", e.kind ? "rdata" : "ack",
                         rsp_obs.val, e.val);
            end
        end
    end

    // Write-pulse monitor: each wr_valid must match the next expected write.
    initial forever begin
        logic [15:0] e;
        @(negedge pclk);
        if (wr_valid) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: got %h/%h expected none", wr_addr, wr_data);
            end else begin
                e = wr_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    errors++;
                    $display("FAIL wr_pulse: got %h/%h expected %h/%h",
                             wr_addr, wr_data, e[15:8], e[7:0]);
                end
            end
        end
    end

    // Count cycles with SDA pulled low by the target.
    initial forever begin
        @(posedge pclk);
        if (sda_oe) oe_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #100;
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        areset_n = 1'b1;
        #100;

        // Write two bytes starting at 0x03
        i2c_start();
        send_byte(8'hD0, 1'b1);
        send_byte(8'h03, 1'b1);
        exp_wr(8'h03, 8'hA5);
        send_byte(8'hA5, 1'b1);
        exp_wr(8'h04, 8'h5A);
        send_byte(8'h5A, 1'b1);
        chk("busy_mid_write", busy, 1);
        i2c_stop();
        #100;
        chk("busy_after_stop", busy, 0);

        // Read back through a repeated START
        i2c_start();
        send_byte(8'hD0, 1'b1);
        send_byte(8'h03, 1'b1);
        i2c_start();
        send_byte(8'hD1, 1'b1);
        recv_byte(8'hA5, 1'b1);
        recv_byte(8'h5A, 1'b0);
        chk("oe_after_nack", sda_oe, 0);
        chk("busy_after_nack", busy, 0);
        i2c_stop();
        #100;

        // Address mismatch: no ACK, SDA never pulled
        oe_snap = oe_cnt;
        i2c_start();
        send_byte(8'hA0, 1'b0);
        chk("busy_mismatch", busy, 0);
        send_byte(8'hFF, 1'b0);
        i2c_stop();
        #100;
        chk("mismatch_oe_cycles", oe_cnt - oe_snap, 0);

        // Pointer wrap on write and read
        i2c_start();
        send_byte(8'hD0, 1'b1);
        send_byte(8'h0F, 1'b1);
        exp_wr(8'h0F, 8'h11);
        send_byte(8'h11, 1'b1);
        exp_wr(8'h00, 8'h22);
        send_byte(8'h22, 1'b1);
        i2c_stop();
        #100;
        i2c_start();
        send_byte(8'hD0, 1'b1);
        send_byte(8'h0F, 1'b1);
        i2c_start();
        send_byte(8'hD1, 1'b1);
        recv_byte(8'h11, 1'b1);
        recv_byte(8'h22, 1'b0);
        i2c_stop();
        #100;

        // STOP after four data bits, then a clean write and read-back
        i2c_start();
        send_byte(8'hD0, 1'b1);
        send_byte(8'h01, 1'b1);
        write_bit(1'b1);
        write_bit(1'b0);
        write_bit(1'b1);
        write_bit(1'b1);
        i2c_stop();
        #100;
        chk("busy_after_partial", busy, 0);
        i2c_start();
        send_byte(8'hD0, 1'b1);
        send_byte(8'h01, 1'b1);
        exp_wr(8'h01, 8'h77);
        send_byte(8'h77, 1'b1);
        i2c_stop();
        #100;
        i2c_start();
        send_byte(8'hD0, 1'b1);
        send_byte(8'h01, 1'b1);
        i2c_start();
        send_byte(8'hD1, 1'b1);
        recv_byte(8'h77, 1'b0);
        i2c_stop();
        #100;

        // Asynchronous reset while the target drives the address ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(((8'hD0 >> i) & 8'h01) != 0);
        chk("ack_driven", sda_oe, 1);
        #3;
        areset_n = 1'b0;
        #1;
        chk("rst_async_sda_oe", sda_oe, 0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        #50;
        chk("rst2_busy", busy, 0);
        chk("rst2_wr_valid", wr_valid, 0);
        chk("rst2_wr_addr", wr_addr, 0);
        chk("rst2_wr_data", wr_data, 0);
        areset_n = 1'b1;
        #96;
        i2c_start();
        send_byte(8'hD1, 1'b1);
        recv_byte(8'h00, 1'b1);
        recv_byte(8'h00, 1'b0);
        i2c_stop();
        #200;

        chk("wr_q_empty", wr_q.size(), 0);
        chk("bus_q_empty", bus_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
